// File: rtl/ucode_pkg.sv
// Shared microcode definitions: widths, control-bit layout, fixed fetch words, sequencer FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a; imported by the sequencer, decoder and datapath so all agree on the bit layout.
package ucode_pkg;

    localparam int unsigned W_UI = 16;   // microinstruction width
    localparam int unsigned W_IR = 16;   // instruction register width
    localparam int unsigned W_T  = 3;    // T-state counter width

    localparam logic [W_T-1:0] T_LAST = 3'd7;   // last legal T-state

    // Microinstruction control-bit layout (bit index of each control line)
    localparam int unsigned BIT_RT   = 0;   // reset T: end of instruction
    localparam int unsigned BIT_JMP  = 1;   // jump: load PC from bus
    localparam int unsigned BIT_PO   = 2;   // PC out onto bus
    localparam int unsigned BIT_PINC = 3;   // PC increment (P+)
    localparam int unsigned BIT_AI   = 4;   // memory address register in
    localparam int unsigned BIT_MO   = 5;   // memory out onto bus
    localparam int unsigned BIT_MI   = 6;   // memory in from bus
    localparam int unsigned BIT_II   = 7;   // instruction register in
    localparam int unsigned BIT_IO   = 8;   // instruction operand out
    localparam int unsigned BIT_RAI  = 9;   // register A in
    localparam int unsigned BIT_RAO  = 10;  // register A out
    localparam int unsigned BIT_RBI  = 11;  // register B in
    localparam int unsigned BIT_ALU  = 12;  // ALU result out
    localparam int unsigned BIT_SUB  = 13;  // ALU subtract select
    localparam int unsigned BIT_OUT  = 14;  // output port in
    localparam int unsigned BIT_HLT  = 15;  // datapath halt

    // One-hot mask for a single control bit
    function automatic logic [W_UI-1:0] ui_bit(input int unsigned idx);
        return {{(W_UI-1){1'b0}}, 1'b1} << idx;
    endfunction

    // T0: PC onto bus, latch into address register
    localparam logic [W_UI-1:0] UI_FETCH0 = ui_bit(BIT_PO) | ui_bit(BIT_AI);
    // T1: memory onto bus, load IR, advance PC
    localparam logic [W_UI-1:0] UI_FETCH1 = ui_bit(BIT_MO) | ui_bit(BIT_II) | ui_bit(BIT_PINC);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/micro_sequencer_if.sv
// Bundle between the sequencer and its decoder/datapath: bus capture, ROM word, stall/halt in; IR, T-state, live word, status out.
// Latency: n/a (wiring only).
// Backpressure: stall freezes the sequencer; halt_req is honoured at instruction boundaries.
interface micro_sequencer_if;

    logic [ucode_pkg::W_IR-1:0] bus_in;      // data bus, captured into IR on II
    logic [ucode_pkg::W_UI-1:0] rom_uinstr;  // decoder output for {instr[15:8], t_state}
    logic                       stall;       // memory not ready
    logic                       halt_req;    // level request to halt at next boundary
    logic [ucode_pkg::W_IR-1:0] instr;       // instruction register
    logic [ucode_pkg::W_T-1:0]  t_state;     // current T-state
    logic [ucode_pkg::W_UI-1:0] uinstr;      // microinstruction in effect this cycle
    logic                       instr_done;  // one-cycle retire pulse
    logic                       halted;      // in HALT
    logic                       t_overflow;  // sticky: a T7 word lacked RT

    // Sequencer side
    modport slave (
        input  bus_in, rom_uinstr, stall, halt_req,
        output instr, t_state, uinstr, instr_done, halted, t_overflow
    );

    // Decoder/datapath side
    modport master (
        output bus_in, rom_uinstr, stall, halt_req,
        input  instr, t_state, uinstr, instr_done, halted, t_overflow
    );

endinterface

// File: rtl/micro_sequencer.sv
// Control-path front end: instruction register, T-state counter and live microinstruction select (fetch words at T0/T1, ROM after).
// Latency: instr/t_state/halted/instr_done/t_overflow update one clock after the qualifying cycle; uinstr is combinational from t_state.
// Backpressure: stall=1 freezes all state; halt_req is sampled only on a retire cycle, resume needs halt_req=0 and stall=0.
//
// Ports: clk, reset (sync, active-high); sif (slave modport): bus_in, rom_uinstr, stall, halt_req in;
//        instr, t_state, uinstr, instr_done, halted, t_overflow out.
module micro_sequencer #(
    parameter logic [ucode_pkg::W_UI-1:0] UI_FETCH0 = ucode_pkg::UI_FETCH0,
    parameter logic [ucode_pkg::W_UI-1:0] UI_FETCH1 = ucode_pkg::UI_FETCH1
) (
    input  logic                    clk,
    input  logic                    reset,
    micro_sequencer_if.slave        sif
);

    import ucode_pkg::*;

    seq_state_t         state_q;
    logic [W_IR-1:0]    instr_q;
    logic [W_T-1:0]     t_state_q;
    logic               instr_done_q;
    logic               t_overflow_q;
    logic [W_UI-1:0]    uinstr_c;
    logic               rt_hit;
    logic               retire;

    // Live microinstruction. HALT forces a no-op so nothing downstream fires.
    always_comb begin
        uinstr_c = sif.rom_uinstr;
        if (state_q == ST_HALT) begin
            uinstr_c = '0;
        end else if (t_state_q == 3'd0) begin
            uinstr_c = UI_FETCH0;
        end else if (t_state_q == 3'd1) begin
            uinstr_c = UI_FETCH1;
        end
    end

    // RT is only honoured from T2 on, so the fetch words can never end an instruction.
    assign rt_hit = uinstr_c[BIT_RT] && (t_state_q >= 3'd2);
    // Running off the end of T7 retires anyway, flagged as an overflow.
    assign retire = rt_hit || (t_state_q == T_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            instr_q      <= '0;
            t_state_q    <= '0;
            instr_done_q <= 1'b0;
            t_overflow_q <= 1'b0;
        end else begin
            instr_done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (!sif.stall) begin
                        // II and RT in the same word both take effect.
                        if (uinstr_c[BIT_II]) begin
                            instr_q <= sif.bus_in;
                        end
                        if (retire) begin
                            t_state_q    <= '0;
                            instr_done_q <= 1'b1;
                            if (!rt_hit) begin
                                t_overflow_q <= 1'b1;
                            end
                            if (sif.halt_req) begin
                                state_q <= ST_HALT;
                            end
                        end else begin
                            t_state_q <= t_state_q + 3'd1;
                        end
                    end
                end
                ST_HALT: begin
                    t_state_q <= '0;
                    if (!sif.halt_req && !sif.stall) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign sif.instr      = instr_q;
    assign sif.t_state    = t_state_q;
    assign sif.uinstr     = uinstr_c;
    assign sif.instr_done = instr_done_q;
    assign sif.halted     = (state_q == ST_HALT);
    assign sif.t_overflow = t_overflow_q;

endmodule
